// File: rtl/mylstar_rom_loader_if.sv
// Download / ROM-write bundle between hps_io, the ROM loader and the board ROM port.
// Modport master is the hps_io + board side; modport slave is the loader.
//
// Handshake: ioctl_wr is a single-cycle strobe. The loader throttles further
// strobes with ioctl_wait. rom_wr is "valid" and rom_ack is "ready". A write
// transfers on the rising edge where rom_wr and rom_ack are both high. rom_wr,
// rom_addr and rom_data are held unchanged until that edge. rom_ack while
// rom_wr is low has no effect.
interface mylstar_rom_loader_if #(
   parameter int AW = 25
);
   logic          ioctl_download;
   logic [7:0]    ioctl_index;
   logic          ioctl_wr;
   logic [AW-1:0] ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic          ioctl_wait;
   logic          rom_wr;
   logic [AW-1:0] rom_addr;
   logic [7:0]    rom_data;
   logic          rom_ack;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
      input  ioctl_wait, rom_wr, rom_addr, rom_data
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
      output ioctl_wait, rom_wr, rom_addr, rom_data
   );
endinterface

// File: rtl/mylstar_rom_loader.sv
// ROM loader for the mylstar / ma216 boards.
// Index 0 downloads are written to the ROM port one byte at a time. hps_io is
// held off with ioctl_wait while a write is pending. Index 1 sets the variant
// byte, and index 254 fills the DIP bytes.
// Optional feature: define ROM_CHECKSUM_EN to accumulate a 16-bit byte sum of
// the accepted ROM bytes. Without it, checksum reads as zero.
module mylstar_rom_loader #(
   parameter int AW      = 25,
   parameter int ROM_LEN = 'h1C000,
   parameter int DIP_N   = 8
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   mylstar_rom_loader_if.slave  bus,
   output logic                 rom_init,
   output logic [7:0]           mod,
   output logic [8*DIP_N-1:0]   dip,
   output logic                 load_done,
   output logic                 load_err,
   output logic [15:0]          checksum,
   output logic [2:0]           fsm_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      PEND  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [AW-1:0] ROM_LEN_C = AW'(ROM_LEN);

   state_t        state, next_state;
   logic          start, issue, accept, overrun, finish;
   logic          rom_wr_q, ioctl_wait_q;
   logic [AW-1:0] rom_addr_q;
   logic [7:0]    rom_data_q;
   logic [AW-1:0] count;

   assign bus.rom_wr     = rom_wr_q;
   assign bus.ioctl_wait = ioctl_wait_q;
   assign bus.rom_addr   = rom_addr_q;
   assign bus.rom_data   = rom_data_q;
   assign fsm_state      = state;

   // State register.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next state and the one-cycle action strobes that the datapath acts on.
   always_comb begin
      next_state = state;
      start      = 1'b0;
      issue      = 1'b0;
      accept     = 1'b0;
      overrun    = 1'b0;
      finish     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.ioctl_download && bus.ioctl_index == 8'd0) begin
               start      = 1'b1;
               next_state = LOAD;
            end
         end
         LOAD: begin
            // A strobe arriving together with the falling download is still written.
            if (bus.ioctl_wr) begin
               issue      = 1'b1;
               next_state = PEND;
            end else if (!bus.ioctl_download) begin
               next_state = DRAIN;
            end
         end
         PEND: begin
            // A strobe here is dropped and flagged; the held write is untouched.
            overrun = bus.ioctl_wr;
            if (bus.rom_ack && rom_wr_q) begin
               accept     = 1'b1;
               next_state = bus.ioctl_download ? LOAD : DRAIN;
            end
         end
         DRAIN: next_state = DONE;
         DONE: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // ROM write port, load-mode flag, byte count and status flags.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rom_wr_q     <= 1'b0;
         ioctl_wait_q <= 1'b0;
         rom_addr_q   <= '0;
         rom_data_q   <= '0;
         rom_init     <= 1'b0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         count        <= '0;
      end else begin
         if (start) begin
            rom_init  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            count     <= '0;
         end
         if (issue) begin
            rom_wr_q     <= 1'b1;
            ioctl_wait_q <= 1'b1;
            rom_addr_q   <= bus.ioctl_addr;
            rom_data_q   <= bus.ioctl_dout;
         end
         if (accept) begin
            rom_wr_q     <= 1'b0;
            ioctl_wait_q <= 1'b0;
            count        <= count + 1'b1;  // wraps freely; only the final compare matters
         end
         if (overrun) load_err <= 1'b1;
         if (finish) begin
            rom_init  <= 1'b0;
            load_done <= 1'b1;
            if (count != ROM_LEN_C) load_err <= 1'b1;
         end
      end
   end

`ifdef ROM_CHECKSUM_EN
   // Running byte sum of accepted ROM bytes, restarted with each image.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)       checksum <= '0;
      else if (start)  checksum <= '0;
      else if (accept) checksum <= checksum + {8'h00, rom_data_q};
   end
`else
   assign checksum = 16'h0000;
`endif

   // Variant and DIP capture; plain register writes with no handshake.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mod <= 8'hFF;
         dip <= '0;
      end else if (bus.ioctl_wr) begin
         if (bus.ioctl_index == 8'd1 && bus.ioctl_addr == '0) mod <= bus.ioctl_dout;
         if (bus.ioctl_index == 8'd254) begin
            for (int k = 0; k < DIP_N; k++) begin
               if (bus.ioctl_addr == AW'(k)) dip[8*k +: 8] <= bus.ioctl_dout;
            end
         end
      end
   end

endmodule

// File: tb/tb_mylstar_rom_loader.sv
// Bench for mylstar_rom_loader: directed cases plus randomized images, checked
// against a byte-level model (expected write queue, sum, count, overrun flag).
module tb_mylstar_rom_loader;
   localparam int AW      = 25;
   localparam int ROM_LEN = 4;
   localparam int DIP_N   = 8;

   // ---------------- clock / reset ----------------
   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_sys = ~clk_sys;

   mylstar_rom_loader_if #(.AW(AW)) bus();

   logic               rom_init;
   logic [7:0]         mod;
   logic [8*DIP_N-1:0] dip;
   logic               load_done;
   logic               load_err;
   logic [15:0]        checksum;
   logic [2:0]         fsm_state;

   mylstar_rom_loader #(.AW(AW), .ROM_LEN(ROM_LEN), .DIP_N(DIP_N)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .bus       (bus.slave),
      .rom_init  (rom_init),
      .mod       (mod),
      .dip       (dip),
      .load_done (load_done),
      .load_err  (load_err),
      .checksum  (checksum),
      .fsm_state (fsm_state)
   );

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [AW+7:0] exp_q[$];
   logic [15:0]   model_sum;
   int            model_count;
   bit            model_overrun;
   logic [7:0]    dip_m[DIP_N];
   logic [7:0]    mod_m;

   function automatic logic [8*DIP_N-1:0] dip_expected();
      logic [8*DIP_N-1:0] v;
      for (int k = 0; k < DIP_N; k++) v[8*k +: 8] = dip_m[k];
      return v;
   endfunction

   function automatic logic [15:0] sum_expected();
`ifdef ROM_CHECKSUM_EN
      return model_sum;
`else
      return 16'h0000;
`endif
   endfunction

   // Scoreboard: every new ROM write request must match the next expected byte.
   logic          prev_wr = 1'b0;
   logic [AW+7:0] sb_e;
   always @(negedge clk_sys) begin
      if (!reset && bus.rom_wr && !prev_wr) begin
         if (exp_q.size() == 0) begin
            check("unexpected rom write", 64'd1, 64'd0);
         end else begin
            sb_e = exp_q.pop_front();
            check("rom write addr/data", {bus.rom_addr, bus.rom_data}, sb_e);
         end
      end
      prev_wr = bus.rom_wr;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic start_load();
      bus.ioctl_index    = 8'd0;
      bus.ioctl_download = 1'b1;
      model_sum     = 16'h0000;
      model_count   = 0;
      model_overrun = 1'b0;
      tick();
      check("rom_init at load start", rom_init, 1'b1);
      check("load_done cleared", load_done, 1'b0);
      check("checksum cleared", checksum, 16'h0000);
   endtask

   task automatic write_byte(input logic [AW-1:0] addr, input logic [7:0] data,
                             input int delay, input bit overrun, input bit last);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = addr;
      bus.ioctl_dout = data;
      exp_q.push_back({addr, data});
      tick();
      bus.ioctl_wr = 1'b0;
      check("rom_wr one cycle after ioctl_wr", bus.rom_wr, 1'b1);
      check("ioctl_wait during write", bus.ioctl_wait, 1'b1);
      for (int i = 0; i < delay; i++) begin
         if (overrun && i == 0) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = addr + AW'(7);
            bus.ioctl_dout = ~data;
            model_overrun  = 1'b1;
         end
         tick();
         bus.ioctl_wr = 1'b0;
         check("rom_wr held until ack", bus.rom_wr, 1'b1);
         check("rom addr/data stable", {bus.rom_addr, bus.rom_data}, {addr, data});
      end
      if (last) bus.ioctl_download = 1'b0;
      bus.rom_ack = 1'b1;
      tick();
      bus.rom_ack = 1'b0;
      model_sum   = model_sum + 16'(data);
      model_count++;
      check("rom_wr drops on ack", bus.rom_wr, 1'b0);
      check("ioctl_wait drops on ack", bus.ioctl_wait, 1'b0);
      if (last) check("rom_init held after last ack", rom_init, 1'b1);
   endtask

   task automatic finish_load();
      int n;
      bus.ioctl_download = 1'b0;
      n = 0;
      while (!load_done && n < 10) begin
         tick();
         n++;
      end
      check("load_done", load_done, 1'b1);
      check("rom_init released", rom_init, 1'b0);
      check("load_err", load_err, model_overrun || (model_count != ROM_LEN));
      check("checksum", checksum, sum_expected());
      check("scoreboard drained", exp_q.size(), 0);
   endtask

   task automatic side_write(input logic [7:0] idx, input logic [AW-1:0] addr, input logic [7:0] data);
      bus.ioctl_index    = idx;
      bus.ioctl_download = 1'b1;
      bus.ioctl_wr       = 1'b1;
      bus.ioctl_addr     = addr;
      bus.ioctl_dout     = data;
      if (idx == 8'd1 && addr == '0) mod_m = data;
      if (idx == 8'd254 && addr < AW'(DIP_N)) dip_m[addr] = data;
      tick();
      bus.ioctl_wr = 1'b0;
      check("rom_init stays low on side download", rom_init, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] b;
      int len;
      bit ovr;
      int dly;
      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 8'd0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = 8'h00;
      bus.rom_ack        = 1'b0;
      mod_m = 8'hFF;
      for (int k = 0; k < DIP_N; k++) dip_m[k] = 8'h00;

      // Reset values
      repeat (3) tick();
      check("reset rom_wr", bus.rom_wr, 1'b0);
      check("reset ioctl_wait", bus.ioctl_wait, 1'b0);
      check("reset rom_addr/data", {bus.rom_addr, bus.rom_data}, '0);
      check("reset rom_init", rom_init, 1'b0);
      check("reset mod", mod, 8'hFF);
      check("reset dip", dip, '0);
      check("reset load_done", load_done, 1'b0);
      check("reset load_err", load_err, 1'b0);
      check("reset checksum", checksum, 16'h0000);
      check("reset fsm idle", fsm_state, 3'd0);
      reset = 1'b0;
      tick();

      // Exact-length image 01..04, ack two cycles after each request
      start_load();
      for (int i = 0; i < 4; i++) write_byte(AW'(i), 8'(i + 1), 2, 1'b0, i == 3);
      finish_load();
      check("checksum 01..04", checksum, sum_expected());

      // Short and long images both flag a length error
      start_load();
      for (int i = 0; i < 3; i++) write_byte(AW'(i), 8'(i + 1), 2, 1'b0, 1'b0);
      finish_load();
      start_load();
      for (int i = 0; i < 5; i++) write_byte(AW'(i), 8'(i + 1), 2, 1'b0, i == 4);
      finish_load();

      // Overrun while the ack is held low
      start_load();
      write_byte(AW'(0), 8'h5A, 3, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) write_byte(AW'(i), 8'(8'h10 + i), 1, 1'b0, i == 3);
      finish_load();

      // Variant and DIP bytes; ROM side stays idle
      side_write(8'd254, AW'(0), 8'hA5);
      side_write(8'd254, AW'(9), 8'h3C);
      side_write(8'd254, AW'(8), 8'h77);
      bus.ioctl_download = 1'b0;
      tick();
      check("dip after index 254", dip, dip_expected());
      side_write(8'd1, AW'(0), 8'h05);
      side_write(8'd1, AW'(3), 8'h99);
      bus.ioctl_download = 1'b0;
      tick();
      check("mod after index 1", mod, 8'h05);
      check("fsm idle after side downloads", fsm_state, 3'd0);
      for (int i = 0; i < 12; i++) side_write(8'd254, AW'($urandom_range(0, 11)), 8'($urandom));
      bus.ioctl_download = 1'b0;
      tick();
      check("dip after random writes", dip, dip_expected());
      check("mod unchanged", mod, mod_m);

      // Reset while a write is pending
      start_load();
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = AW'(0);
      bus.ioctl_dout = 8'hEE;
      tick();
      bus.ioctl_wr = 1'b0;
      check("pending before reset", bus.rom_wr, 1'b1);
      reset = 1'b1;
      bus.ioctl_download = 1'b0;
      #1;
      check("rom_wr drops on reset", bus.rom_wr, 1'b0);
      check("rom_init drops on reset", rom_init, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      start_load();
      for (int i = 0; i < 4; i++) write_byte(AW'(i), 8'(i + 1), 1, 1'b0, i == 3);
      finish_load();
      check("dip survives only until reset", dip, '0);

      // Randomized images with random ack delays, stray acks and occasional overruns
      for (int k = 0; k < DIP_N; k++) dip_m[k] = 8'h00;
      for (int img = 0; img < 8; img++) begin
         start_load();
         len = $urandom_range(2, 6);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               bus.rom_ack = 1'b1;
               tick();
               bus.rom_ack = 1'b0;
            end
            b   = 8'($urandom);
            dly = $urandom_range(0, 3);
            ovr = (dly > 0) && ($urandom_range(0, 7) == 0);
            write_byte(AW'($urandom_range(0, 'hFFFF)), b, dly, ovr,
                       (i == len - 1) && ($urandom_range(0, 1) == 1));
         end
         finish_load();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends on its own
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
